// File: rtl/uitpg_pro.sv
// ============================================================================
// Module   : uitpg_pro
// Function : Video test-pattern generator; 12 patterns, manual/auto selection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uitpg_pro #(
    parameter int DATA_W      = 8,
    parameter int H_ACT       = 1920,
    parameter int V_ACT       = 1080,
    parameter int GRID_LOG2   = 4,
    parameter int HOLD_FRAMES = 128,
    parameter int BOX_SIZE    = 64
) (
    input  logic                  tpg_clk_i,
    input  logic                  tpg_rst_i,
    input  logic                  tpg_vs_i,
    input  logic                  tpg_hs_i,
    input  logic                  tpg_de_i,
    input  logic                  tpg_auto_i,
    input  logic [3:0]            tpg_mode_i,
    output logic                  tpg_vs_o,
    output logic                  tpg_hs_o,
    output logic                  tpg_de_o,
    output logic [3*DATA_W-1:0]   tpg_data_o,
    output logic [3:0]            tpg_mode_o,
    output logic [15:0]           tpg_frame_o
);

    localparam int                c_BAR_W     = H_ACT / 8;
    localparam int                c_BOX_XMAX  = H_ACT - BOX_SIZE;
    localparam int                c_BOX_YMAX  = V_ACT - BOX_SIZE;
    localparam logic [11:0]       c_XY_MAX    = 12'hFFF;
    localparam logic [DATA_W-1:0] c_M         = '1;
    localparam logic [DATA_W-1:0] c_Z         = '0;
    localparam logic [0:0]        c_ST_MANUAL = 1'b0;
    localparam logic [0:0]        c_ST_AUTO   = 1'b1;

    logic        r_vs_d, r_de_d;
    logic [11:0] r_x, r_y, r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic        w_fs;

    logic        r_s1_vs, r_s1_hs, r_s1_de;
    logic [11:0] r_s1_x, r_s1_y;
    logic [2:0]  r_s1_bar;

    logic [0:0]  r_state, w_state_nxt;
    logic [3:0]  r_mode, w_mode_nxt, w_mode_sel;
    logic [15:0] r_hold, w_hold_nxt;
    logic [15:0] r_frame;
    logic [11:0] r_box_x, r_box_y;
    logic        r_dir_x, r_dir_y;

    logic                w_in_box, w_on_border;
    logic [3*DATA_W-1:0] w_rgb;

    assign w_fs = tpg_vs_i & ~r_vs_d;

    // Stage 0: pixel coordinates and bar index for the pixel on the inputs now
    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) begin
            r_vs_d    <= 1'b0;
            r_de_d    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else begin
            r_vs_d <= tpg_vs_i;
            r_de_d <= tpg_de_i;
            if (tpg_de_i) begin
                if (r_x != c_XY_MAX) r_x <= r_x + 12'd1;
                if (r_bar_cnt == 12'(c_BAR_W - 1)) begin
                    r_bar_cnt <= '0;
                    if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 12'd1;
                end
            end else begin
                r_x       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end
            if (w_fs)
                r_y <= '0;
            else if (r_de_d && !tpg_de_i && r_y != c_XY_MAX)
                r_y <= r_y + 12'd1;
        end
    end

    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) begin
            r_s1_vs  <= 1'b0;
            r_s1_hs  <= 1'b0;
            r_s1_de  <= 1'b0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_bar <= '0;
        end else begin
            r_s1_vs  <= tpg_vs_i;
            r_s1_hs  <= tpg_hs_i;
            r_s1_de  <= tpg_de_i;
            r_s1_x   <= r_x;
            r_s1_y   <= r_y;
            r_s1_bar <= r_bar_idx;
        end
    end

    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) r_state <= c_ST_MANUAL;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fs) w_state_nxt = tpg_auto_i ? c_ST_AUTO : c_ST_MANUAL;
    end

    assign w_mode_sel = (tpg_mode_i > 4'd11) ? 4'd0 : tpg_mode_i;

    always_comb begin
        w_mode_nxt = r_mode;
        w_hold_nxt = r_hold;
        if (w_fs) begin
            if (w_state_nxt == c_ST_MANUAL) begin
                w_mode_nxt = w_mode_sel;
            end else if (r_state == c_ST_MANUAL) begin
                w_hold_nxt = '0;
            end else if (r_hold == 16'(HOLD_FRAMES - 1)) begin
                w_mode_nxt = (r_mode == 4'd11) ? 4'd0 : r_mode + 4'd1;
                w_hold_nxt = '0;
            end else begin
                w_hold_nxt = r_hold + 16'd1;
            end
        end
    end

    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) begin
            r_mode  <= '0;
            r_hold  <= '0;
            r_frame <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_hold <= w_hold_nxt;
            if (w_fs) r_frame <= r_frame + 16'd1;
        end
    end

    // Box bounces: on hitting a limit the direction flips and the move is taken the other way
    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) begin
            r_box_x <= '0;
            r_box_y <= '0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (w_fs) begin
            if (!r_dir_x) begin
                if ({1'b0, r_box_x} + 13'd2 > 13'(c_BOX_XMAX)) begin
                    r_dir_x <= 1'b1;
                    r_box_x <= r_box_x - 12'd2;
                end else r_box_x <= r_box_x + 12'd2;
            end else begin
                if (r_box_x < 12'd2) begin
                    r_dir_x <= 1'b0;
                    r_box_x <= r_box_x + 12'd2;
                end else r_box_x <= r_box_x - 12'd2;
            end
            if (!r_dir_y) begin
                if ({1'b0, r_box_y} + 13'd2 > 13'(c_BOX_YMAX)) begin
                    r_dir_y <= 1'b1;
                    r_box_y <= r_box_y - 12'd2;
                end else r_box_y <= r_box_y + 12'd2;
            end else begin
                if (r_box_y < 12'd2) begin
                    r_dir_y <= 1'b0;
                    r_box_y <= r_box_y + 12'd2;
                end else r_box_y <= r_box_y - 12'd2;
            end
        end
    end

    assign w_in_box = (r_s1_x >= r_box_x) && ({1'b0, r_s1_x} < {1'b0, r_box_x} + 13'(BOX_SIZE)) &&
                      (r_s1_y >= r_box_y) && ({1'b0, r_s1_y} < {1'b0, r_box_y} + 13'(BOX_SIZE));
    assign w_on_border = (r_s1_x == 12'd0) || (r_s1_x == 12'(H_ACT - 1)) ||
                         (r_s1_y == 12'd0) || (r_s1_y == 12'(V_ACT - 1));

    always_comb begin
        w_rgb = {c_Z, c_Z, c_Z};
        case (r_mode)
            4'd1:  w_rgb = {c_M, c_M, c_M};
            4'd2:  w_rgb = {c_M, c_Z, c_Z};
            4'd3:  w_rgb = {c_Z, c_M, c_Z};
            4'd4:  w_rgb = {c_Z, c_Z, c_M};
            4'd5:  if (!(r_s1_x[GRID_LOG2] ^ r_s1_y[GRID_LOG2])) w_rgb = {c_M, c_M, c_M};
            4'd6:  w_rgb = {3{r_s1_x[DATA_W-1:0]}};
            4'd7:  w_rgb = {3{r_s1_y[DATA_W-1:0]}};
            4'd8: begin
                case (r_s1_bar)
                    3'd0:    w_rgb = {c_M, c_M, c_M};
                    3'd1:    w_rgb = {c_M, c_M, c_Z};
                    3'd2:    w_rgb = {c_Z, c_M, c_M};
                    3'd3:    w_rgb = {c_Z, c_M, c_Z};
                    3'd4:    w_rgb = {c_M, c_Z, c_M};
                    3'd5:    w_rgb = {c_M, c_Z, c_Z};
                    3'd6:    w_rgb = {c_Z, c_Z, c_M};
                    default: w_rgb = {c_Z, c_Z, c_Z};
                endcase
            end
            4'd9:  if (w_in_box) w_rgb = {c_M, c_M, c_M};
            4'd10: if (w_on_border) w_rgb = {c_M, c_M, c_M};
            4'd11: w_rgb = {r_s1_x[DATA_W-1:0], r_s1_y[DATA_W-1:0], r_frame[DATA_W-1:0]};
            default: w_rgb = {c_Z, c_Z, c_Z};
        endcase
    end

    always_ff @(posedge tpg_clk_i) begin
        if (tpg_rst_i) begin
            tpg_vs_o   <= 1'b0;
            tpg_hs_o   <= 1'b0;
            tpg_de_o   <= 1'b0;
            tpg_data_o <= '0;
        end else begin
            tpg_vs_o   <= r_s1_vs;
            tpg_hs_o   <= r_s1_hs;
            tpg_de_o   <= r_s1_de;
            tpg_data_o <= r_s1_de ? w_rgb : '0;
        end
    end

    assign tpg_mode_o  = r_mode;
    assign tpg_frame_o = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_uitpg_pro.sv
// ============================================================================
// Module   : tb_uitpg_pro
// Function : Self-checking bench for uitpg_pro against a coordinate-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uitpg_pro;

    localparam int DATA_W      = 8;
    localparam int H_ACT       = 48;
    localparam int V_ACT       = 12;
    localparam int GRID_LOG2   = 2;
    localparam int HOLD_FRAMES = 2;
    localparam int BOX_SIZE    = 8;
    localparam int H_TOT       = H_ACT + 8;
    localparam int BAR_W       = H_ACT / 8;
    localparam int XMAX        = H_ACT - BOX_SIZE;
    localparam int YMAX        = V_ACT - BOX_SIZE;

    logic clk = 1'b0;
    logic rst, vs, hs, de, auto_i;
    logic [3:0] mode_i;
    logic vs_o, hs_o, de_o;
    logic [3*DATA_W-1:0] data_o;
    logic [3:0]  mode_o;
    logic [15:0] frame_o;

    uitpg_pro #(
        .DATA_W(DATA_W), .H_ACT(H_ACT), .V_ACT(V_ACT), .GRID_LOG2(GRID_LOG2),
        .HOLD_FRAMES(HOLD_FRAMES), .BOX_SIZE(BOX_SIZE)
    ) dut (
        .tpg_clk_i(clk), .tpg_rst_i(rst), .tpg_vs_i(vs), .tpg_hs_i(hs), .tpg_de_i(de),
        .tpg_auto_i(auto_i), .tpg_mode_i(mode_i), .tpg_vs_o(vs_o), .tpg_hs_o(hs_o),
        .tpg_de_o(de_o), .tpg_data_o(data_o), .tpg_mode_o(mode_o), .tpg_frame_o(frame_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, expressed in screen coordinates
    int m_x = 0, m_y = 0, m_prev_vs = 0, m_prev_de = 0;
    int m_mode = 0, m_hold = 0, m_auto = 0, m_frame = 0;
    int bx = 0, by = 0, dx = 1, dy = 1;
    int cur_mode = 0, cur_auto = 0;
    logic [26:0] e1 = '0, e2 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        logic [23:0] w;
        int idx;
        w = 24'hFFFFFF;
        case (mode)
            1:  pix = w;
            2:  pix = 24'hFF0000;
            3:  pix = 24'h00FF00;
            4:  pix = 24'h0000FF;
            5:  pix = ((((x >> GRID_LOG2) & 1) ^ ((y >> GRID_LOG2) & 1)) == 0) ? w : 24'h0;
            6:  pix = {3{8'(x & 255)}};
            7:  pix = {3{8'(y & 255)}};
            8: begin
                idx = x / BAR_W;
                if (idx > 7) idx = 7;
                case (idx)
                    0: pix = 24'hFFFFFF;
                    1: pix = 24'hFFFF00;
                    2: pix = 24'h00FFFF;
                    3: pix = 24'h00FF00;
                    4: pix = 24'hFF00FF;
                    5: pix = 24'hFF0000;
                    6: pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            9:  pix = (x >= bx && x < bx + BOX_SIZE && y >= by && y < by + BOX_SIZE) ? w : 24'h0;
            10: pix = (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) ? w : 24'h0;
            11: pix = {8'(x & 255), 8'(y & 255), 8'(m_frame & 255)};
            default: pix = 24'h0;
        endcase
    endfunction

    task automatic step(input bit r, input bit v, input bit h, input bit d);
        int nxt;
        @(negedge clk);
        chk("pipe", 32'({vs_o, hs_o, de_o, data_o}), 32'(e2));
        chk("mode_o", 32'(mode_o), 32'(m_mode));
        chk("frame_o", 32'(frame_o), 32'(m_frame));
        rst = r; vs = v; hs = h; de = d;
        mode_i = 4'(cur_mode); auto_i = 1'(cur_auto);
        e2 = e1;
        if (r) begin
            e2 = '0; e1 = '0;
            m_x = 0; m_y = 0; m_prev_vs = 0; m_prev_de = 0;
            m_mode = 0; m_hold = 0; m_auto = 0; m_frame = 0;
            bx = 0; by = 0; dx = 1; dy = 1;
        end else begin
            if (v && !m_prev_vs) begin
                if (cur_auto != 0) begin
                    if (m_auto == 0) m_hold = 0;
                    else if (m_hold == HOLD_FRAMES - 1) begin
                        m_mode = (m_mode + 1) % 12;
                        m_hold = 0;
                    end else m_hold++;
                    m_auto = 1;
                end else begin
                    m_mode = (cur_mode > 11) ? 0 : cur_mode;
                    m_auto = 0;
                end
                m_frame = (m_frame + 1) % 65536;
                nxt = bx + 2 * dx;
                if (nxt > XMAX || nxt < 0) begin dx = -dx; nxt = bx + 2 * dx; end
                bx = nxt;
                nxt = by + 2 * dy;
                if (nxt > YMAX || nxt < 0) begin dy = -dy; nxt = by + 2 * dy; end
                by = nxt;
                m_y = 0;
            end else if (m_prev_de != 0 && !d && m_y < 4095) begin
                m_y++;
            end
            e1 = {v, h, d, d ? pix(m_mode, m_x, m_y) : 24'h0};
            m_x = d ? ((m_x < 4095) ? m_x + 1 : m_x) : 0;
            m_prev_vs = v;
            m_prev_de = d;
        end
    endtask

    task automatic line(input bit v, input bit active);
        for (int c = 0; c < H_TOT; c++) step(1'b0, v, c < 4, active && c >= 8);
    endtask

    // chg >= 0: switch mode_i to chg mid-frame; chg == -2: random mid-frame mode/auto
    task automatic run_frame(input int auto_v, input int mode_v, input int chg);
        cur_auto = auto_v;
        cur_mode = mode_v;
        line(1'b1, 1'b0);
        line(1'b0, 1'b0);
        line(1'b0, 1'b0);
        for (int l = 0; l < V_ACT; l++) begin
            if (l == 6) begin
                if (chg >= 0) cur_mode = chg;
                else if (chg == -2) begin
                    cur_mode = int'($urandom_range(0, 15));
                    cur_auto = int'($urandom_range(0, 1));
                end
            end
            line(1'b0, 1'b1);
        end
        line(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; auto_i = 1'b0; mode_i = 4'd0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mode", 32'(mode_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);

        run_frame(0, 2, -1);
        run_frame(0, 2, -1);
        chk("red_mode", 32'(mode_o), 32'd2);

        for (int i = 0; i < 10; i++) run_frame(0, int'($urandom_range(0, 15)), -2);

        run_frame(0, 3, 5);
        chk("mid_chg_mode", 32'(mode_o), 32'd3);
        run_frame(0, 5, -1);
        run_frame(0, 14, -1);
        chk("mode14_zero", 32'(mode_o), 32'd0);
        run_frame(0, 8, -1);
        run_frame(0, 9, -1);
        run_frame(0, 10, -1);
        run_frame(0, 0, -1);

        for (int k = 0; k < 26; k++) begin
            run_frame(1, int'($urandom_range(0, 15)), -1);
            chk("auto_seq", 32'(mode_o), 32'((k / 2) % 12));
        end

        run_frame(0, 9, -1);
        run_frame(0, 11, -1);
        cur_mode = 11;
        line(1'b1, 1'b0);
        line(1'b0, 1'b0);
        line(1'b0, 1'b0);
        line(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, c < 4, c >= 8);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_de", 32'(de_o), 32'd0);
        chk("rst_mid_frame", 32'(frame_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(0, 11, -1);
        chk("frame_after_rst", 32'(frame_o), 32'd1);
        run_frame(0, 11, -2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uitpg_pro.md
UITPG_PRO -- requirements
Module: uitpg_pro

Interface
REQ-001 Parameter DATA_W, 8, bits per colour channel (range 8..10).
REQ-002 Parameter H_ACT, 1920, active pixels per line.
REQ-003 Parameter V_ACT, 1080, active lines per frame.
REQ-004 Parameter GRID_LOG2, 4, grid cell size is 2^GRID_LOG2 pixels square.
REQ-005 Parameter HOLD_FRAMES, 128, frames per pattern in auto mode (>=1).
REQ-006 Parameter BOX_SIZE, 64, moving-box edge length in pixels.
REQ-007 tpg_clk_i  in  1  sole clock; all logic rising-edge.
REQ-008 tpg_rst_i  in  1  reset, synchronous, active-high.
REQ-009 tpg_vs_i / tpg_hs_i / tpg_de_i  in  1 each  input timing; vs/hs active-high, de high on active pixels.
REQ-010 tpg_auto_i  in  1  1 = cycle patterns automatically, 0 = manual select.
REQ-011 tpg_mode_i  in  4  manual pattern index.
REQ-012 tpg_vs_o / tpg_hs_o / tpg_de_o  out  1 each  inputs delayed exactly 2 cycles.
REQ-013 tpg_data_o  out  3*DATA_W  {R,G,B}, aligned with tpg_de_o.
REQ-014 tpg_mode_o  out  4  pattern currently displayed.
REQ-015 tpg_frame_o  out  16  frame counter.

Function
REQ-016 Frame start (FS) SHALL be a one-cycle event on tpg_vs_i rising edge (0 in previous cycle, 1 now).
REQ-017 x (12 bit) = count of de-high cycles earlier in the line; 0 on first de cycle; cleared while de low; saturates at 4095.
REQ-018 y (12 bit) SHALL clear on FS and increment on each de falling edge; saturates at 4095; FS wins over a simultaneous edge.
REQ-019 Pipeline SHALL be 2 cycles: input pixel at cycle t appears on tpg_data_o at t+2 with its delayed syncs; tpg_data_o = 0 whenever tpg_de_o = 0.
REQ-020 Mode and auto/manual state SHALL change only on FS; mid-frame changes to tpg_mode_i/tpg_auto_i have no visible effect until next FS.
REQ-021 FSM states MANUAL and AUTO; at FS next state = AUTO if tpg_auto_i else MANUAL.
REQ-022 MANUAL: mode <= tpg_mode_i at FS; values 12..15 map to 0.
REQ-023 AUTO: hold counter increments per FS; on FS with hold = HOLD_FRAMES-1, mode <= (mode+1) mod 12 and hold <= 0.
REQ-024 MANUAL->AUTO keeps current mode and clears hold counter.
REQ-025 Patterns, M = 2^DATA_W-1: 0 black; 1 white; 2 red; 3 green; 4 blue.
REQ-026 5 grid: white when x[GRID_LOG2] XOR y[GRID_LOG2] = 0, else black.
REQ-027 6 horizontal gray ramp R=G=B=x[DATA_W-1:0]; 7 vertical ramp using y.
REQ-028 8 colour bars, BAR_W = H_ACT/8 (integer), order white, yellow, cyan, green, magenta, red, blue, black; bar index by pixel-in-bar counter (no divider), saturates at 7.
REQ-029 9 moving box: white where box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE, else black.
REQ-030 Box moves 2 px per axis per FS; axis direction reverses when next position would exceed H_ACT-BOX_SIZE (or V_ACT-BOX_SIZE) or go below 0; box updates in all modes.
REQ-031 10 border: white where x=0, x=H_ACT-1, y=0 or y=V_ACT-1, else black.
REQ-032 11 RGB sweep: R=x[DATA_W-1:0], G=y[DATA_W-1:0], B=tpg_frame_o[DATA_W-1:0].
REQ-033 tpg_frame_o SHALL increment on each FS, wrapping 65535->0.
REQ-034 tpg_mode_o SHALL change on the cycle after FS.

Reset
REQ-035 While tpg_rst_i=1 (next edge): all outputs, pipeline, x, y, mode, hold, frame = 0; state MANUAL; box (0,0), direction +x,+y.
REQ-036 First 2 cycles after reset release, outputs remain 0; reset mid-frame blanks output at the next edge.

Verification
REQ-037 Manual, tpg_mode_i=2, 1920x1080 timing -> every de_o pixel = {M,0,0}; syncs lag inputs exactly 2 cycles.
REQ-038 Mode 8, H_ACT=1920 -> x 0..239 white, x 240 yellow, x 1680..1919 black.
REQ-039 Auto, HOLD_FRAMES=2 -> tpg_mode_o 0,0,1,1,2,...,11,11,0 over 24 frames.
REQ-040 tpg_mode_i 3->5 mid-frame -> output stays green to end of frame, grid from next frame; tpg_mode_i=14 -> black.
REQ-041 Mode 9, BOX_SIZE=64, H_ACT=1920 -> box_x reaches 1856 then decreases by 2 per frame.
REQ-042 Reset asserted mid-line in mode 11 -> data/syncs/mode/frame 0 next cycle; after release, tpg_frame_o=1 after first FS.
